// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - handshake, enable and status bundle between pipe_ctrl and its environment
interface pipe_ctrl_if #(
   parameter int stages   = 4,
   parameter int cntwidth = 16
);
   logic                          IN_VALID;
   logic                          IN_READY;
   logic                          OUT_VALID;
   logic                          OUT_READY;
   logic                          FLUSH;
   logic [stages-1:0]             EN;
   logic [$clog2(stages+1)-1:0]   COUNT;
   logic [cntwidth-1:0]           STALL_CNT;
   logic                          BUSY;

   // Environment side: offers operands, accepts results, requests flushes.
   modport master (
      output IN_VALID, OUT_READY, FLUSH,
      input  IN_READY, OUT_VALID, EN, COUNT, STALL_CNT, BUSY
   );

   // Sequencer side.
   modport slave (
      input  IN_VALID, OUT_READY, FLUSH,
      output IN_READY, OUT_VALID, EN, COUNT, STALL_CNT, BUSY
   );
endinterface

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - valid/ready sequencer producing per-stage load enables for a fixed-depth pipeline
module pipe_ctrl #(
   parameter int stages   = 4,
   parameter int cntwidth = 16
) (
   input  logic       CLK,
   input  logic       RST,
   pipe_ctrl_if.slave bus
);
   localparam int CW = $clog2(stages + 1);

   logic [stages-1:0]   r_v;
   logic [CW-1:0]       r_count;
   logic [cntwidth-1:0] r_stall;

   logic [stages-1:0]   w_chain;
   logic [stages-1:0]   w_en;
   logic                w_in_ready;
   logic                w_out_valid;
   logic                w_acc;
   logic                w_del;
   logic                w_stalled;

   // Ready ripples back from the output: a stage may load when it is empty or its successor loads.
   always_comb begin
      w_chain           = '0;
      w_chain[stages-1] = !r_v[stages-1] | bus.OUT_READY;
      for (int i = stages - 2; i >= 0; i--) begin
         w_chain[i] = !r_v[i] | w_chain[i+1];
      end
   end

   // Flush opens every enable but blocks both handshakes for that cycle.
   always_comb begin
      w_en        = bus.FLUSH ? '1 : w_chain;
      w_in_ready  = w_chain[0] & !bus.FLUSH;
      w_out_valid = r_v[stages-1] & !bus.FLUSH;
      w_acc       = bus.IN_VALID & w_in_ready;
      w_del       = w_out_valid & bus.OUT_READY;
      w_stalled   = r_v[stages-1] & !bus.OUT_READY & !bus.FLUSH;
   end

   // Valid bits advance through every enabled stage; a disabled stage holds its bit.
   always_ff @(posedge CLK) begin
      if (RST || bus.FLUSH) begin
         r_v <= '0;
      end else begin
         if (w_chain[0]) begin
            r_v[0] <= bus.IN_VALID;
         end
         for (int i = 1; i < stages; i++) begin
            if (w_chain[i]) begin
               r_v[i] <= r_v[i-1];
            end
         end
      end
   end

   // Occupancy tracks accepts minus deliveries, so it always equals the number of set valid bits.
   always_ff @(posedge CLK) begin
      if (RST || bus.FLUSH) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + CW'(w_acc) - CW'(w_del);
      end
   end

   // Backpressure cycles are counted up to all-ones and then held; flush leaves the count alone.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_stall <= '0;
      end else if (w_stalled && (r_stall != '1)) begin
         r_stall <= r_stall + cntwidth'(1);
      end
   end

   assign bus.EN        = w_en;
   assign bus.IN_READY  = w_in_ready;
   assign bus.OUT_VALID = w_out_valid;
   assign bus.COUNT     = r_count;
   assign bus.STALL_CNT = r_stall;
   assign bus.BUSY      = (r_count != '0);
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl with a 4-stage and a 1-stage instance
module tb_pipe_ctrl;
   logic clk = 1'b0;
   logic rst4;
   logic rst1;
   always #5 clk = ~clk;

   pipe_ctrl_if #(.stages(4), .cntwidth(4))  bus4 ();
   pipe_ctrl_if #(.stages(1), .cntwidth(16)) bus1 ();

   pipe_ctrl #(.stages(4), .cntwidth(4))  u_dut4 (.CLK(clk), .RST(rst4), .bus(bus4.slave));
   pipe_ctrl #(.stages(1), .cntwidth(16)) u_dut1 (.CLK(clk), .RST(rst1), .bus(bus1.slave));

   int checks = 0;
   int errors = 0;
   int cyc_no = 0;

   // Reference model: occupancy per stage slot, stall counter, depth and counter width.
   int  m_st;
   int  m_w;
   int  m_stall;
   bit  m_full[4];

   // Scoreboard: accepted tags in order, and a shadow datapath clocked by the DUT enables.
   int  sb_q[$];
   int  dp[4];
   int  tag_next = 0;

   // Actual outputs sampled in the current cycle.
   logic [3:0]  a_en;
   logic        a_ir;
   logic        a_ov;
   logic        a_busy;
   logic [2:0]  a_cnt;
   logic [15:0] a_stall;

   typedef struct {
      bit         rst;
      bit         iv;
      bit         ordy;
      bit         fl;
      bit         ir;
      bit         ov;
      logic [3:0] en;
      int         cnt;
      int         stall;
   } vec_t;
   vec_t tbl[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc_no, act, exp);
      end
   endtask

   task automatic model_init(input int st, input int w);
      m_st    = st;
      m_w     = w;
      m_stall = 0;
      for (int i = 0; i < 4; i++) m_full[i] = 1'b0;
      sb_q.delete();
   endtask

   // One clock cycle on the selected instance: drive, sample, compare with the model, advance.
   task automatic cyc(input bit sel1, input bit rst, input bit iv, input bit ordy, input bit fl);
      logic [3:0] e_en;
      bit         e_ir;
      bit         e_ov;
      bit         hole;
      bit         acc;
      bit         del;
      int         e_cnt;
      int         last;
      int         want;
      @(negedge clk);
      if (sel1) begin
         rst1 = rst; bus1.IN_VALID = iv; bus1.OUT_READY = ordy; bus1.FLUSH = fl;
      end else begin
         rst4 = rst; bus4.IN_VALID = iv; bus4.OUT_READY = ordy; bus4.FLUSH = fl;
      end
      #1;
      if (sel1) begin
         a_en = {3'b000, bus1.EN}; a_ir = bus1.IN_READY; a_ov = bus1.OUT_VALID;
         a_cnt = {2'b00, bus1.COUNT}; a_busy = bus1.BUSY; a_stall = bus1.STALL_CNT;
      end else begin
         a_en = bus4.EN; a_ir = bus4.IN_READY; a_ov = bus4.OUT_VALID;
         a_cnt = bus4.COUNT; a_busy = bus4.BUSY; a_stall = {12'h000, bus4.STALL_CNT};
      end
      last = m_st - 1;
      // A stage can take new data when the output is draining or some slot at or beyond it is empty.
      e_en = '0;
      hole = 1'b0;
      for (int i = last; i >= 0; i--) begin
         hole    = hole | !m_full[i];
         e_en[i] = fl | ordy | hole;
      end
      e_ir  = e_en[0] & !fl;
      e_ov  = m_full[last] & !fl;
      e_cnt = 0;
      for (int i = 0; i < m_st; i++) e_cnt += int'(m_full[i]);
      chk("model_en", 32'(a_en), 32'(e_en));
      chk("model_in_ready", 32'(a_ir), 32'(e_ir));
      chk("model_out_valid", 32'(a_ov), 32'(e_ov));
      chk("model_count", 32'(a_cnt), 32'(e_cnt));
      chk("model_busy", 32'(a_busy), 32'(e_cnt != 0));
      chk("model_stall_cnt", 32'(a_stall), 32'(m_stall));

      if (!rst) begin
         del = a_ov & ordy;
         acc = iv & a_ir;
         if (del) begin
            chk("delivery_has_pending_tag", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
               want = sb_q.pop_front();
               chk("delivered_tag", 32'(dp[last]), 32'(want));
            end
         end
         for (int i = last; i >= 1; i--) if (a_en[i]) dp[i] = dp[i-1];
         if (a_en[0]) dp[0] = tag_next;
         if (acc) begin
            sb_q.push_back(tag_next);
            tag_next++;
         end
      end
      if (rst || fl) sb_q.delete();

      if (rst) begin
         for (int i = 0; i < 4; i++) m_full[i] = 1'b0;
         m_stall = 0;
      end else if (fl) begin
         for (int i = 0; i < 4; i++) m_full[i] = 1'b0;
      end else begin
         if (m_full[last] && !ordy && (m_stall < (1 << m_w) - 1)) m_stall++;
         for (int i = last; i >= 1; i--) if (e_en[i]) m_full[i] = m_full[i-1];
         if (e_en[0]) m_full[0] = iv;
      end
      cyc_no++;
   endtask

   task automatic drain(input bit sel1);
      for (int i = 0; i <= m_st; i++) cyc(sel1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("drain_nothing_lost", 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      int  delivered;
      int  maxcnt;
      bit  ordy;

      rst4 = 1'b1; rst1 = 1'b1;
      bus4.IN_VALID = 1'b0; bus4.OUT_READY = 1'b0; bus4.FLUSH = 1'b0;
      bus1.IN_VALID = 1'b0; bus1.OUT_READY = 1'b0; bus1.FLUSH = 1'b0;
      repeat (2) @(negedge clk);
      model_init(4, 4);

      // Directed table: backpressure fill, release, flush at COUNT=3, reset mid-stream.
      //            rst iv or fl   ir ov  en       cnt stall
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 0, 0};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 0, 0};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 1, 0};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 2, 0};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 3, 0};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4, 0};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4, 1};
      tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1111, 4, 2};
      tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1111, 4, 2};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0001, 3, 2};
      tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1111, 3, 3};
      tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1111, 0, 3};
      tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1111, 0, 3};
      tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 1, 3};
      tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 2, 3};
      tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 0, 0};
      for (int r = 0; r < 16; r++) begin
         cyc(1'b0, tbl[r].rst, tbl[r].iv, tbl[r].ordy, tbl[r].fl);
         chk($sformatf("tbl%0d_in_ready", r), 32'(a_ir), 32'(tbl[r].ir));
         chk($sformatf("tbl%0d_out_valid", r), 32'(a_ov), 32'(tbl[r].ov));
         chk($sformatf("tbl%0d_en", r), 32'(a_en), 32'(tbl[r].en));
         chk($sformatf("tbl%0d_count", r), 32'(a_cnt), 32'(tbl[r].cnt));
         chk($sformatf("tbl%0d_busy", r), 32'(a_busy), 32'(tbl[r].cnt != 0));
         chk($sformatf("tbl%0d_stall_cnt", r), 32'(a_stall), 32'(tbl[r].stall));
      end

      // Streaming: 10 operands back to back, output always ready.
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      delivered = 0;
      maxcnt    = 0;
      for (int t = 0; t < 16; t++) begin
         cyc(1'b0, 1'b0, t < 10, 1'b1, 1'b0);
         chk("stream_out_valid", 32'(a_ov), 32'(t >= 4 && t <= 13));
         chk("stream_en", 32'(a_en), 32'hF);
         if (a_ov) delivered++;
         if (int'(a_cnt) > maxcnt) maxcnt = int'(a_cnt);
      end
      chk("stream_max_count", 32'(maxcnt), 32'd4);
      chk("stream_delivered", 32'(delivered), 32'd10);
      chk("stream_none_pending", 32'(sb_q.size()), 32'd0);

      // Bubble collapse: valid pattern 1,0,1,0 then a 3-cycle output stall.
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int t = 0; t < 4; t++) cyc(1'b0, 1'b0, (t % 2) == 0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("bubble_en_first_stall", 32'(a_en), 32'b0111);
      for (int k = 0; k < 2; k++) begin
         cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         chk("bubble_en_compacted", 32'(a_en), 32'b0011);
         chk("bubble_in_ready", 32'(a_ir), 32'd1);
         chk("bubble_count", 32'(a_cnt), 32'd2);
      end
      for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("bubble_released_in_order", 32'(sb_q.size()), 32'd0);

      // Stall counter saturation, then reset in the middle of traffic.
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 24; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("stall_saturated", 32'(a_stall), 32'd15);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("post_reset_count", 32'(a_cnt), 32'd0);
      chk("post_reset_stall_cnt", 32'(a_stall), 32'd0);
      chk("post_reset_out_valid", 32'(a_ov), 32'd0);
      chk("post_reset_in_ready", 32'(a_ir), 32'd1);
      chk("post_reset_en", 32'(a_en), 32'hF);

      // Randomised traffic on the 4-stage instance: a drain-biased phase, then a fill-biased one.
      for (int k = 0; k < 600; k++) begin
         ordy = (k < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         cyc(1'b0, $urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, ordy,
             $urandom_range(0, 19) == 0);
      end
      drain(1'b0);

      // Single-stage instance.
      rst4 = 1'b1;
      model_init(1, 16);
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int t = 0; t < 20; t++) begin
         ordy = (t % 2) == 0;
         cyc(1'b1, 1'b0, 1'b1, ordy, 1'b0);
         chk("s1_in_ready_follows", 32'(a_ir), 32'(ordy));
      end
      drain(1'b1);
      for (int k = 0; k < 300; k++) begin
         cyc(1'b1, $urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0,
             $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
      end
      drain(1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
